d_latch: RTL and testbench
==========================

D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 Parameter WIDTH, default 1, data path width of D, Q and Qb.
REQ-002 Parameter RESET_VALUE, default all-zeros, value loaded into Q while reset is asserted.
REQ-003 Clk  input  1  latch gate; transparent phase is Clk=1, and the design has one clock only.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears the latch, reset=1 is normal operation.
REQ-005 D  input  WIDTH  data input.
REQ-006 en  input  1  gate enable; the latch is transparent only while Clk=1 and en=1.
REQ-007 Q  output  WIDTH  latched data.
REQ-008 Qb  output  WIDTH  bitwise complement of Q.
REQ-009 Positional port order SHALL be D, Clk, en, reset, Q, Qb.

Function
REQ-010 Level-sensitive storage, not edge-triggered; there is no clock-edge sampling anywhere in the block.
REQ-011 Transparent condition (reset=1, Clk=1, en=1): Q SHALL follow D combinationally, with zero cycles of latency and no delay beyond gate evaluation.
REQ-012 Opaque condition (reset=1 and Clk=0 or en=0): Q SHALL hold the last value present when the transparent condition ended.
REQ-013 Closing the latch while D changes in the same timestep: Q SHALL hold the D value that was stable immediately before the closing event.
REQ-014 Qb SHALL equal ~Q at all times, including during reset, so Q and Qb are never equal.
REQ-015 en=0 SHALL block transparency regardless of Clk, so Q holds.
REQ-016 Each bit SHALL behave independently when WIDTH>1, with no cross-bit coupling.
REQ-017 Glitch handling: D toggles during a transparent phase SHALL each propagate to Q.
REQ-018 Before the first reset or transparent phase, Q and Qb are unknown (X in simulation); no power-on value is guaranteed.

Reset
REQ-019 reset=0 SHALL force Q=RESET_VALUE and Qb=~RESET_VALUE immediately, independent of Clk, en and D.
REQ-020 Reset SHALL dominate transparency; D changes while reset=0 SHALL NOT affect Q.
REQ-021 On reset release (0->1) in the transparent condition, Q SHALL take the current D value immediately.
REQ-022 On reset release in the opaque condition, Q SHALL keep RESET_VALUE until the next transparent phase.
REQ-023 A reset pulse of any width, including 1 ns, SHALL clear the stored value; there is no minimum pulse width.

Verification
Common stimulus (WIDTH=1): Clk starts at 0 and toggles every 10 ns, so it is high 10-20, 30-40, 50-60 and 70-80 ns; D starts at 0 and toggles every 7 ns; en=1; reset=1 except where stated.
REQ-024 Transparency: t=10 (Clk rises, D=1) -> Q=1, Qb=0; t=14 (D falls) -> Q=0, Qb=1.
REQ-025 Hold: t=20 (Clk falls, D=0) then t=21 (D rises) -> Q stays 0 until t=30.
REQ-026 Reset during transparent phase: reset=0 at t=51 with D=1 and Clk=1 -> Q=0 at t=51; release at t=52 -> Q=1 at t=52; t=56 (D falls) -> Q=0.
REQ-027 Reset during opaque phase: set Q=1, then drop Clk; reset=0 from t=62 to t=63 -> Q=0, Qb=1, and Q stays 0 until the next Clk high phase.
REQ-028 Enable gating: en=0 while Clk=1 and D toggles -> Q unchanged; set en=1 with Clk still high -> Q=D at once.
REQ-029 Invariant checked at every timestep of all scenarios after the first defined value: Qb == ~Q.

Source files
------------

// File: rtl/d_latch.sv
// rtl/d_latch.sv - level-sensitive D latch with enable and asynchronous active-low reset
//
// Purpose:
//   Transparent while Clk=1 and en=1: Q follows D with no clock-edge sampling.
//   Otherwise Q holds the value present when the transparent condition ended.
//   reset=0 forces Q=RESET_VALUE at once and dominates transparency.
//
// Parameters:
//   WIDTH        data path width of D, Q and Qb
//   RESET_VALUE  value held in Q while reset is asserted
//
// Ports (positional order D, Clk, en, reset, Q, Qb):
//   D      in   [WIDTH-1:0]  data input
//   Clk    in   1            latch gate, transparent phase is Clk=1
//   en     in   1            gate enable, transparency needs en=1 as well
//   reset  in   1            asynchronous active-low clear
//   Q      out  [WIDTH-1:0]  latched data
//   Qb     out  [WIDTH-1:0]  bitwise complement of Q
module d_latch #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] D,
  input  logic             Clk,
  input  logic             en,
  input  logic             reset,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb
);

  logic             gate_open;
  logic [WIDTH-1:0] q_r;

  assign gate_open = Clk & en;

  // Reset is checked first so it wins over an open gate; on release with the
  // gate open the next branch picks up the current D in the same evaluation.
  // Each bit is stored independently; the vector form adds no coupling.
  always_latch begin
    if (!reset) begin
      q_r <= RESET_VALUE;
    end else if (gate_open) begin
      q_r <= D;
    end
  end

  assign Q  = q_r;
  // Qb derives from the stored value, so it is the complement during reset too.
  assign Qb = ~q_r;

endmodule

// File: tb/tb_d_latch.sv
// tb/tb_d_latch.sv - self-checking bench for d_latch
module tb_d_latch;

  // Time unit: one spec nanosecond is 10 simulator time units.
  // Instance A: WIDTH=1, RESET_VALUE=0 for the timed scenarios.
  logic       d_a, clk_a, en_a, rst_a;
  logic       q_a, qb_a;
  // Instance B: WIDTH=8, RESET_VALUE=8'hA5 for randomized checking.
  logic [7:0] d_b;
  logic       clk_b, en_b, rst_b;
  logic [7:0] q_b, qb_b;

  int errors = 0;
  int checks = 0;

  d_latch u_a (
    .D     (d_a),
    .Clk   (clk_a),
    .en    (en_a),
    .reset (rst_a),
    .Q     (q_a),
    .Qb    (qb_a)
  );

  d_latch #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_b (
    .D     (d_b),
    .Clk   (clk_b),
    .en    (en_b),
    .reset (rst_b),
    .Q     (q_b),
    .Qb    (qb_b)
  );

  typedef struct {
    int   t;
    logic q;
    logic qb;
  } vec_t;

  vec_t vecs[$];

  task automatic check1(input string name, input int t, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%b expected=%b", name, t, act, exp);
    end
  endtask

  task automatic check8(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s iter=%0d actual=%h expected=%h", name, i, act, exp);
    end
  endtask

  // Common stimulus with scenario overrides, all as functions of spec time t (ns).
  function automatic logic stim_clk(input int t);
    return ((t / 10) % 2) == 1;
  endfunction

  function automatic logic stim_d(input int t);
    if (t >= 57 && t <= 61) return 1'b1;          // charge Q=1 before the opaque-phase reset
    if (t >= 70 && t <= 74) return logic'(t % 2);  // D toggles while en=0 and Clk=1
    if (t >= 75 && t <= 76) return 1'b1;          // D=1 when en returns
    if (t >= 95 && t <= 99) return 1'b1;          // D=1 just before the closing edge at 100
    return logic'((t / 7) % 2);
  endfunction

  function automatic logic stim_en(input int t);
    return !(t >= 65 && t <= 74);
  endfunction

  function automatic logic stim_rst(input int t);
    return !(t == 51 || t == 62);
  endfunction

  // Reference: a bit vector updated by the rules "reset clears to the reset value,
  // open gate copies D, otherwise nothing changes", evaluated on settled inputs.
  logic       ref_a;
  logic [7:0] ref_b;

  initial begin
    logic [7:0] rv;
    bit         open;

    vecs = '{
      '{10, 1'b1, 1'b0}, '{14, 1'b0, 1'b1}, '{20, 1'b0, 1'b1}, '{21, 1'b0, 1'b1},
      '{29, 1'b0, 1'b1}, '{51, 1'b0, 1'b1}, '{52, 1'b1, 1'b0}, '{56, 1'b0, 1'b1},
      '{58, 1'b1, 1'b0}, '{61, 1'b1, 1'b0}, '{62, 1'b0, 1'b1}, '{63, 1'b0, 1'b1},
      '{69, 1'b0, 1'b1}, '{71, 1'b0, 1'b1}, '{73, 1'b0, 1'b1}, '{75, 1'b1, 1'b0},
      '{80, 1'b1, 1'b0}, '{100, 1'b1, 1'b0}, '{103, 1'b1, 1'b0}
    };

    ref_a = 1'bx;
    d_b = '0; clk_b = 1'b0; en_b = 1'b0; rst_b = 1'b1;

    // Phase 1: timed scenarios on instance A. Clk is driven before D so a
    // closing gate and a D change in the same step settle together.
    for (int t = 0; t < 110; t++) begin
      clk_a = stim_clk(t);
      en_a  = stim_en(t);
      rst_a = stim_rst(t);
      d_a   = stim_d(t);
      #5;
      if (!rst_a)             ref_a = 1'b0;
      else if (clk_a && en_a) ref_a = d_a;
      if (t >= 10) begin
        check1("model_q", t, q_a, ref_a);
        check1("qb_inv", t, qb_a, ~q_a);
      end
      foreach (vecs[k]) begin
        if (vecs[k].t == t) begin
          check1("vec_q", t, q_a, vecs[k].q);
          check1("vec_qb", t, qb_a, vecs[k].qb);
        end
      end
      #5;
    end

    // Phase 2: instance B reset state with the gate open and D toggling.
    rv    = 8'hA5;
    rst_b = 1'b0; clk_b = 1'b1; en_b = 1'b1; d_b = 8'h3C;
    #5;
    check8("rst_q", 0, q_b, rv);
    check8("rst_qb", 0, qb_b, ~rv);
    d_b = 8'hFF;
    #5;
    check8("rst_dom_q", 0, q_b, rv);
    ref_b = rv;

    // Phase 3: randomized per-bit checks against the reference.
    for (int i = 1; i <= 300; i++) begin
      rst_b = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) != 0) clk_b = ~clk_b;
      en_b  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) d_b = 8'($urandom);
      #5;
      open = rst_b && clk_b && en_b;
      for (int b = 0; b < 8; b++) begin
        if (!rst_b)    ref_b[b] = rv[b];
        else if (open) ref_b[b] = d_b[b];
      end
      check8("rand_q", i, q_b, ref_b);
      check8("rand_qb", i, qb_b, ~ref_b);
      #5;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
